// File: rtl/jt10_adpcm_romrsp.sv
// rtl/jt10_adpcm_romrsp.sv - ADPCM-A ROM responder: per-channel byte cache, cs/ok fetch FSM, nibble return one cen later
module jt10_adpcm_romrsp #(
    parameter int LATE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic [5:0]        cur_ch,
    input  logic [19:0]       addr,
    input  logic [3:0]        bank,
    input  logic              sel,
    input  logic              roe_n,
    input  logic              clr,
    output logic [23:0]       rom_addr,
    output logic              rom_cs,
    input  logic [7:0]        rom_data,
    input  logic              rom_ok,
    output logic [3:0]        dout,
    output logic              dvalid,
    output logic [LATE_W-1:0] late
);
    typedef enum logic {IDLE, FETCH} state_t;

    state_t      state_q, state_d;
    logic [7:0]  byte_q  [6];
    logic [23:0] tag_q   [6];
    logic [5:0]  valid_q;
    logic [2:0]  fetch_k_q;
    logic [23:0] rom_addr_q;
    logic        discard_q;
    logic        pend_vld_q;
    logic [2:0]  pend_k_q;
    logic [23:0] pend_a_q;
    logic        out_vld_q;
    logic [2:0]  out_k_q;
    logic        out_sel_q;
    logic [23:0] out_a_q;
    logic [3:0]  dout_q;
    logic        dvalid_q;
    logic [LATE_W-1:0] late_q, late_d;

    logic [2:0]  slot_k;
    logic [23:0] req_a;
    logic        acc, do_clr, do_req;
    logic        fill, fill_wr;
    logic        lk_valid;
    logic [23:0] lk_tag;
    logic        hit, miss, pend_take, start_new, pend_wr, overwrite;
    logic        o_hit, late_out;
    logic [1:0]  late_inc;
    logic [LATE_W:0] late_sum;

    always_comb begin
        slot_k = '0;
        for (int i = 0; i < 6; i++)
            if (cur_ch[i]) slot_k = 3'(i);
    end

    assign req_a   = {bank, addr};
    assign acc     = cen && $onehot(cur_ch);
    assign do_clr  = acc && clr;
    assign do_req  = acc && !roe_n;
    assign fill    = (state_q == FETCH) && rom_ok;
    assign fill_wr = fill && !discard_q;

    // Lookup sees a fill landing on this same edge, and clr overrides everything.
    always_comb begin
        lk_valid = valid_q[slot_k];
        lk_tag   = tag_q[slot_k];
        if (fill_wr && fetch_k_q == slot_k) begin
            lk_valid = 1'b1;
            lk_tag   = rom_addr_q;
        end
        if (clr) lk_valid = 1'b0;
    end

    assign hit       = lk_valid && (lk_tag == req_a);
    assign miss      = do_req && !hit;
    assign pend_take = (state_q == IDLE) && pend_vld_q;
    assign start_new = miss && (state_q == IDLE) && !pend_vld_q;
    assign pend_wr   = miss && !start_new;
    assign overwrite = pend_wr && pend_vld_q && !pend_take;

    assign o_hit    = out_vld_q && valid_q[out_k_q] && (tag_q[out_k_q] == out_a_q);
    assign late_out = cen && out_vld_q && !o_hit;
    assign late_inc = {1'b0, late_out} + {1'b0, overwrite};
    assign late_sum = {1'b0, late_q} + (LATE_W+1)'(late_inc);
    assign late_d   = late_sum[LATE_W] ? '1 : late_sum[LATE_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pend_vld_q || start_new) state_d = FETCH;
            FETCH:   if (rom_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rom_cs = (state_q == FETCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                byte_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            valid_q    <= '0;
            fetch_k_q  <= '0;
            rom_addr_q <= '0;
            discard_q  <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_k_q   <= '0;
            pend_a_q   <= '0;
            out_vld_q  <= 1'b0;
            out_k_q    <= '0;
            out_sel_q  <= 1'b0;
            out_a_q    <= '0;
            dout_q     <= '0;
            dvalid_q   <= 1'b0;
            late_q     <= '0;
        end else begin
            late_q <= late_d;
            if (fill_wr) begin
                byte_q[fetch_k_q]  <= rom_data;
                tag_q[fetch_k_q]   <= rom_addr_q;
                valid_q[fetch_k_q] <= 1'b1;
            end
            if (do_clr) valid_q[slot_k] <= 1'b0;

            if (state_q == IDLE && (pend_vld_q || start_new)) begin
                discard_q  <= 1'b0;
                fetch_k_q  <= pend_vld_q ? pend_k_q : slot_k;
                rom_addr_q <= pend_vld_q ? pend_a_q : req_a;
            end else if (do_clr && state_q == FETCH && fetch_k_q == slot_k) begin
                discard_q <= 1'b1;
            end

            if (pend_wr) begin
                pend_vld_q <= 1'b1;
                pend_k_q   <= slot_k;
                pend_a_q   <= req_a;
            end else if (pend_take) begin
                pend_vld_q <= 1'b0;
            end

            if (cen) begin
                out_vld_q <= do_req;
                if (do_req) begin
                    out_k_q   <= slot_k;
                    out_sel_q <= sel;
                    out_a_q   <= req_a;
                end
                dvalid_q <= o_hit;
                dout_q   <= !o_hit ? 4'h0 :
                            out_sel_q ? byte_q[out_k_q][3:0] : byte_q[out_k_q][7:4];
            end
        end
    end

    assign rom_addr = rom_addr_q;
    assign dout     = dout_q;
    assign dvalid   = dvalid_q;
    assign late     = late_q;
endmodule

// File: tb/tb_jt10_adpcm_romrsp.sv
// tb/tb_jt10_adpcm_romrsp.sv - randomized bench for jt10_adpcm_romrsp against a transaction-level cache/ROM model
module tb_jt10_adpcm_romrsp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b0;
    logic [5:0]  cur_ch = '0;
    logic [19:0] addr = '0;
    logic [3:0]  bank = '0;
    logic        sel = 1'b0;
    logic        roe_n = 1'b1;
    logic        clr = 1'b0;
    logic [23:0] rom_addr;
    logic        rom_cs;
    logic [7:0]  rom_data = '0;
    logic        rom_ok = 1'b0;
    logic [3:0]  dout;
    logic        dvalid;
    logic [7:0]  late;

    jt10_adpcm_romrsp #(.LATE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .cur_ch(cur_ch), .addr(addr), .bank(bank),
        .sel(sel), .roe_n(roe_n), .clr(clr), .rom_addr(rom_addr), .rom_cs(rom_cs),
        .rom_data(rom_data), .rom_ok(rom_ok), .dout(dout), .dvalid(dvalid), .late(late)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [23:0] a;
        int          k;
    } req_t;

    // Reference model state: what the cache holds, what the ROM is busy with, what is owed next cen.
    bit          m_valid [6];
    logic [23:0] m_tag   [6];
    logic [7:0]  m_byte  [6];
    bit          m_fetching;
    int          m_fk;
    logic [23:0] m_fa;
    bit          m_disc;
    int          m_cnt;
    req_t        pend[$];
    bit          m_ov;
    int          m_ok;
    bit          m_osel;
    logic [23:0] m_oa;
    logic [3:0]  e_dout;
    bit          e_dvalid;
    int          e_late;

    bit          rom_stall = 0;
    bit          force_req = 0;
    logic [23:0] pool [6];

    function automatic logic [7:0] rom_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = '0;
            m_byte[i]  = '0;
        end
        m_fetching = 0; m_fk = 0; m_fa = '0; m_disc = 0; m_cnt = 0;
        pend.delete();
        m_ov = 0; m_ok = 0; m_osel = 0; m_oa = '0;
        e_dout = '0; e_dvalid = 0; e_late = 0;
    endtask

    task automatic start_fetch(input logic [23:0] a, input int k);
        m_fetching = 1;
        m_fa   = a;
        m_fk   = k;
        m_disc = 0;
        m_cnt  = $urandom_range(0, 11);
    endtask

    // One clock edge, told as a sequence of events: answer owed, ROM fill, queue pickup, new request.
    task automatic model_edge();
        bit          old_f = m_fetching;
        bit          took = 0;
        int          inc = 0;
        int          k = -1;
        int          nset = 0;
        logic [23:0] a = {bank, addr};
        req_t        p;
        for (int i = 0; i < 6; i++) if (cur_ch[i]) begin k = i; nset++; end

        if (cen) begin
            if (m_ov && m_valid[m_ok] && m_tag[m_ok] == m_oa) begin
                e_dvalid = 1;
                e_dout   = m_osel ? m_byte[m_ok][3:0] : m_byte[m_ok][7:4];
            end else begin
                e_dvalid = 0;
                e_dout   = '0;
                if (m_ov) inc++;
            end
        end

        if (old_f && rom_ok) begin
            if (!m_disc) begin
                m_byte[m_fk]  = rom_data;
                m_tag[m_fk]   = m_fa;
                m_valid[m_fk] = 1;
            end
            m_fetching = 0;
        end

        if (!old_f && pend.size() > 0) begin
            p = pend.pop_front();
            start_fetch(p.a, p.k);
            took = 1;
        end

        if (cen) begin
            m_ov = 0;
            if (nset == 1) begin
                if (clr) begin
                    m_valid[k] = 0;
                    if (old_f && m_fk == k) m_disc = 1;
                end
                if (!roe_n) begin
                    m_ov = 1; m_ok = k; m_osel = sel; m_oa = a;
                    if (!(m_valid[k] && m_tag[k] == a)) begin
                        if (!old_f && !took) begin
                            start_fetch(a, k);
                        end else begin
                            if (pend.size() > 0) begin
                                inc++;
                                pend.delete();
                            end
                            p.a = a; p.k = k;
                            pend.push_back(p);
                        end
                    end
                end
            end
        end

        e_late = (e_late + inc > 255) ? 255 : e_late + inc;
    endtask

    task automatic cycle(input bit c);
        int r;
        @(negedge clk);
        cen = c;
        r = $urandom_range(0, 19);
        if (r == 0)      cur_ch = 6'd0;
        else if (r == 1) cur_ch = 6'b000011 << $urandom_range(0, 4);
        else             cur_ch = 6'b000001 << $urandom_range(0, 5);
        {bank, addr} = ($urandom_range(0, 9) == 0) ? 24'($urandom) : pool[$urandom_range(0, 5)];
        sel   = 1'($urandom);
        roe_n = force_req ? 1'b0 : ($urandom_range(0, 9) < 3);
        clr   = force_req ? 1'b0 : ($urandom_range(0, 19) < 3);
        if (m_fetching && !rom_stall) begin
            if (m_cnt == 0) rom_ok = 1'b1;
            else begin rom_ok = 1'b0; m_cnt--; end
        end else begin
            rom_ok = !m_fetching && ($urandom_range(0, 9) == 0);
        end
        rom_data = (rom_ok && m_fetching) ? rom_byte(m_fa) : 8'($urandom);
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        #1;
        check_eq("rom_cs", {31'd0, rom_cs}, {31'd0, m_fetching});
        if (m_fetching) check_eq("rom_addr", {8'd0, rom_addr}, {8'd0, m_fa});
        check_eq("dvalid", {31'd0, dvalid}, {31'd0, e_dvalid});
        check_eq("dout", {28'd0, dout}, {28'd0, e_dout});
        check_eq("late", {24'd0, late}, e_late);
    endtask

    task automatic run_cens(input int n);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 8; j++) cycle(j == 0);
    endtask

    initial begin
        pool[0] = 24'h012345;
        pool[1] = 24'h812345;
        pool[2] = 24'h012344;
        pool[3] = 24'h000100;
        pool[4] = 24'($urandom);
        pool[5] = 24'($urandom);
        model_reset();

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0);
        check_eq("rst_rom_addr", {8'd0, rom_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_cens(600);

        rom_stall = 1;
        force_req = 1;
        run_cens(300);
        check_eq("late_sat", {24'd0, late}, 32'd255);
        check_eq("cs_before_rst", {31'd0, rom_cs}, {31'd0, m_fetching});

        rst_n = 1'b0;
        #1;
        check_eq("rst_async_cs", {31'd0, rom_cs}, 32'd0);
        check_eq("rst_async_late", {24'd0, late}, 32'd0);
        check_eq("rst_async_dvalid", {31'd0, dvalid}, 32'd0);
        model_reset();
        rom_stall = 0;
        force_req = 0;
        cycle(1'b1);
        cycle(1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_cens(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
